// File: rtl/td4_register_bank.sv
// TD4 architectural state: A/B/OUT/PC registers, carry flag, sticky multi-load error, operand mux.
// Latency: register writes are visible 1 cycle after the enabled edge; OPERAND is combinational (0 cycles).
// Backpressure: none; EN=0 freezes all state, and synchronous active-low RST overrides EN.
//
// Ports:
//   CLK, RST (sync, active-low), EN (instruction strobe)
//   LOAD[3:0] one-hot target {PC, OUT, B, A}; SEL[1:0] operand source {zero, IN_PORT, B, A}
//   SUM/COUT  adder result and carry-out; IN_PORT external switches
//   OPERAND   adder IN_Y operand; A_REG, B_REG, OUT_PORT, PC, C_FLAG, ERR state outputs
module td4_register_bank #(
   parameter int                DATA_W = 4,
   parameter logic [DATA_W-1:0] PC_RST = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [3:0]        LOAD,
   input  logic [1:0]        SEL,
   input  logic [DATA_W-1:0] SUM,
   input  logic              COUT,
   input  logic [DATA_W-1:0] IN_PORT,
   output logic [DATA_W-1:0] OPERAND,
   output logic [DATA_W-1:0] A_REG,
   output logic [DATA_W-1:0] B_REG,
   output logic [DATA_W-1:0] OUT_PORT,
   output logic [DATA_W-1:0] PC,
   output logic              C_FLAG,
   output logic              ERR
);

   // More than one bit set: clearing the lowest set bit leaves something behind.
   logic multi_load;
   assign multi_load = (LOAD & (LOAD - 4'd1)) != 4'd0;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         A_REG    <= '0;
         B_REG    <= '0;
         OUT_PORT <= '0;
         PC       <= PC_RST;
         C_FLAG   <= 1'b0;
         ERR      <= 1'b0;
      end else if (EN) begin
         if (LOAD[0]) A_REG    <= SUM;
         if (LOAD[1]) B_REG    <= SUM;
         if (LOAD[2]) OUT_PORT <= SUM;
         // A jump replaces the increment; otherwise PC wraps modulo 2^DATA_W.
         PC     <= LOAD[3] ? SUM : PC + DATA_W'(1);
         // Carry is recorded on every retired instruction, NOPs included.
         C_FLAG <= COUT;
         if (multi_load) ERR <= 1'b1;
      end
   end

   // Reads pre-edge register values, so read-modify-write in one instruction is hazard-free.
   always_comb begin
      OPERAND = '0;
      unique case (SEL)
         2'b00:   OPERAND = A_REG;
         2'b01:   OPERAND = B_REG;
         2'b10:   OPERAND = IN_PORT;
         default: OPERAND = '0;
      endcase
   end

endmodule

// File: tb/tb_td4_register_bank.sv
module tb_td4_register_bank;

   localparam int DATA_W = 4;

   logic              CLK = 1'b0;
   logic              RST;
   logic              EN;
   logic [3:0]        LOAD;
   logic [1:0]        SEL;
   logic [DATA_W-1:0] SUM;
   logic              COUT;
   logic [DATA_W-1:0] IN_PORT;
   logic [DATA_W-1:0] OPERAND;
   logic [DATA_W-1:0] A_REG;
   logic [DATA_W-1:0] B_REG;
   logic [DATA_W-1:0] OUT_PORT;
   logic [DATA_W-1:0] PC;
   logic              C_FLAG;
   logic              ERR;

   int errors = 0;
   int checks = 0;

   td4_register_bank #(.DATA_W(DATA_W), .PC_RST(4'd0)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .SEL(SEL), .SUM(SUM),
      .COUT(COUT), .IN_PORT(IN_PORT), .OPERAND(OPERAND), .A_REG(A_REG),
      .B_REG(B_REG), .OUT_PORT(OUT_PORT), .PC(PC), .C_FLAG(C_FLAG), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One rising edge, then settle away from the edge before sampling or driving.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic drive(input logic en, input logic [3:0] ld, input logic [3:0] s, input logic c);
      EN = en; LOAD = ld; SUM = s; COUT = c;
   endtask

   initial begin
      RST = 1'b0; EN = 1'b0; LOAD = 4'b0000; SEL = 2'b00;
      SUM = '0; COUT = 1'b0; IN_PORT = '0;

      // Reset for two edges.
      step(2);
      check("rst_a",   A_REG,    0);
      check("rst_b",   B_REG,    0);
      check("rst_out", OUT_PORT, 0);
      check("rst_pc",  PC,       0);
      check("rst_c",   C_FLAG,   0);
      check("rst_err", ERR,      0);

      // Release and load A on the first edge.
      RST = 1'b1;
      drive(1'b1, 4'b0001, 4'd5, 1'b0);
      step(1);
      check("rel_a",  A_REG,  5);
      check("rel_pc", PC,     1);
      check("rel_c",  C_FLAG, 0);

      // Jump to 0, then 16 NOPs wrap PC back to 0.
      drive(1'b1, 4'b1000, 4'd0, 1'b0);
      step(1);
      check("jmp0_pc", PC, 0);
      drive(1'b1, 4'b0000, 4'd7, 1'b0);
      step(15);
      check("nop15_pc", PC, 15);
      check("nop_a_hold", A_REG, 5);
      step(1);
      check("wrap_pc", PC, 0);
      drive(1'b1, 4'b1000, 4'd9, 1'b0);
      step(1);
      check("jmp9_pc", PC, 9);

      // A=3, B=12 (PC 10, 11).
      drive(1'b1, 4'b0001, 4'd3, 1'b0);
      step(1);
      drive(1'b1, 4'b0010, 4'd12, 1'b0);
      step(1);
      EN = 1'b0;
      IN_PORT = 4'd7;
      SEL = 2'b00; #1 check("sel_a",    OPERAND, 3);
      SEL = 2'b01; #1 check("sel_b",    OPERAND, 12);
      SEL = 2'b10; #1 check("sel_in",   OPERAND, 7);
      SEL = 2'b11; #1 check("sel_zero", OPERAND, 0);
      SEL = 2'b10; IN_PORT = 4'd2; #1 check("sel_in_live", OPERAND, 2);
      IN_PORT = 4'd7;
      SEL = 2'b01;

      // Carry capture with a B load (PC 12), then a NOP clears it (PC 13).
      drive(1'b1, 4'b0010, 4'd15, 1'b1);
      step(1);
      check("cy_b",   B_REG,   15);
      check("cy_c1",  C_FLAG,  1);
      check("cy_opb", OPERAND, 15);
      drive(1'b1, 4'b0000, 4'd0, 1'b0);
      step(1);
      check("cy_c0", C_FLAG, 0);
      check("cy_pc", PC,     13);

      // Hold: EN low with every load bit set must change nothing.
      drive(1'b0, 4'b1111, 4'd6, 1'b1);
      step(3);
      check("hold_a",   A_REG,    3);
      check("hold_b",   B_REG,    15);
      check("hold_out", OUT_PORT, 0);
      check("hold_pc",  PC,       13);
      check("hold_c",   C_FLAG,   0);
      check("hold_err", ERR,      0);

      // Multi-bit load: both targets written, ERR set, PC increments (14).
      drive(1'b1, 4'b0101, 4'd4, 1'b0);
      step(1);
      check("ml_a",   A_REG,    4);
      check("ml_out", OUT_PORT, 4);
      check("ml_b",   B_REG,    15);
      check("ml_err", ERR,      1);
      check("ml_pc",  PC,       14);

      // ERR is sticky across valid loads.
      drive(1'b1, 4'b0010, 4'd1, 1'b0);
      step(1);
      check("st_b",   B_REG, 1);
      check("st_err", ERR,   1);
      drive(1'b1, 4'b0000, 4'd0, 1'b0);
      step(1);
      check("st_pc_wrap", PC,  0);
      check("st_err2",    ERR, 1);

      // Move PC away from reset value, then reset coincident with a load.
      drive(1'b1, 4'b1000, 4'd6, 1'b1);
      step(1);
      check("pre_rst_pc", PC, 6);
      RST = 1'b0;
      drive(1'b1, 4'b0001, 4'd10, 1'b1);
      step(1);
      check("mr_a",   A_REG,    0);
      check("mr_pc",  PC,       0);
      check("mr_err", ERR,      0);
      check("mr_c",   C_FLAG,   0);
      check("mr_out", OUT_PORT, 0);

      // First edge after release executes normally.
      RST = 1'b1;
      drive(1'b1, 4'b0000, 4'd0, 1'b0);
      step(1);
      check("post_pc", PC, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/td4_register_bank.md
# td4_register_bank

Architectural state block of the TD4 datapath, directly downstream of the ALU full adder and closing the loop back to its input. Captures the adder's sum into the one-hot-selected register (A, B, OUT, PC) and its carry-out into the carry flag, advances the PC when the PC is not the load target, and drives the operand selector that feeds the adder's IN_Y input. One instruction retires per enabled clock.

## Interface

- DATA_W, default 4: width of every data register, the sum bus and the operand bus.
- PC_RST, default 0: PC value after reset (DATA_W bits).

- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-low reset; sampled on rising CLK.
- EN  input  1  instruction strobe; state updates only when high.
- LOAD  input  4  one-hot load select: [0]=A, [1]=B, [2]=OUT, [3]=PC.
- SEL  input  2  operand source: 00=A, 01=B, 10=IN_PORT, 11=zero.
- SUM  input  DATA_W  adder data result.
- COUT  input  1  adder carry-out.
- IN_PORT  input  DATA_W  external input switches.
- OPERAND  output  DATA_W  operand to adder IN_Y, combinational from SEL and current state.
- A_REG, B_REG  output  DATA_W  general registers.
- OUT_PORT  output  DATA_W  output register.
- PC  output  DATA_W  program counter.
- C_FLAG  output  1  carry flag from the previous retired instruction.
- ERR  output  1  sticky error flag: a multi-bit LOAD was seen.

## Operation

- Reset (RST=0 at rising CLK) overrides EN:
  - A_REG, B_REG, OUT_PORT, C_FLAG and ERR go to 0.
  - PC goes to PC_RST.
- EN=0 with RST=1: all registers hold, including ERR.
- EN=1 with RST=1, evaluated per rising edge:
  - Each register whose LOAD bit is set captures SUM.
  - If LOAD[3]=0, PC <= PC+1 modulo 2^DATA_W. 15 wraps to 0 at DATA_W=4, with no carry and no flag.
  - If LOAD[3]=1, PC <= SUM (jump). No increment is applied.
  - C_FLAG <= COUT on every enabled cycle, regardless of LOAD. This includes LOAD=0000, where the cycle is a NOP that still records the carry.
  - More than one LOAD bit set: every selected register loads SUM and ERR is set to 1. ERR clears only on reset.
- OPERAND mux, purely combinational:
  - SEL=00 selects A_REG, 01 selects B_REG, 10 selects IN_PORT, 11 selects 0.
  - It reflects register values before the current edge.
  - A register can therefore be read and written in the same instruction (for example A <= A + imm) without a hazard.
- The ALU's carry input is not driven by this block. C_FLAG is consumed only by the upstream decoder for the conditional jump (JNC).

## Timing

- Write latency is 1 cycle: SUM and COUT sampled at edge N are visible on the outputs after edge N.
- OPERAND has 0-cycle latency from SEL, IN_PORT or a register change.
- C_FLAG always describes the most recent enabled cycle. It is valid for the decode of the next instruction.
- Reset mid-operation (RST low coincident with EN=1 and any LOAD): reset wins and no load occurs.
- Release: RST=1 with EN=1 on the first edge after reset executes normally, so PC becomes PC_RST+1.
- No combinational path from SUM or COUT to any output.

## Test plan

- Reset, then release and load: RST=0 for 2 cycles, then EN=1, LOAD=0001, SUM=5, COUT=0. Required: after reset all outputs are 0 (PC=PC_RST, ERR=0). After one edge: A_REG=5, PC=1, C_FLAG=0.
- PC wrap and jump:
  - 16 enabled cycles with LOAD=0000 from PC=0 -> PC returns to 0.
  - Then LOAD=1000, SUM=9 -> PC=9, not 10.
- Operand mux and carry: A_REG=3, B_REG=12, IN_PORT=7.
  - Sweep SEL 00..11 -> OPERAND = 3, 12, 7, 0.
  - One cycle with COUT=1, LOAD=0010, SUM=15 -> B_REG=15, C_FLAG=1.
  - Next cycle with COUT=0 -> C_FLAG=0.
- Hold: EN=0 for 3 cycles with LOAD=1111, SUM=6, COUT=1 -> no register, PC or C_FLAG change.
- Multi-load error: EN=1, LOAD=0101, SUM=4.
  - Required: A_REG=4, OUT_PORT=4, ERR=1.
  - ERR stays 1 through later valid loads and clears only on RST=0.
- Reset mid-operation: RST=0 coincident with EN=1, LOAD=0001, SUM=10 -> A_REG=0, PC=PC_RST.
